// File: rtl/frame_sched_pkg.sv
// Shared types and sizing helpers for the MFCC frame scheduler.
package frame_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FILL,
    READ,
    GAP,
    DRAIN,
    HOP
  } sched_state_t;

  // Index width for a frame of n samples (at least 1 bit)
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FRAME_SIZE_DEF = 306;
  localparam int IDX_W          = idx_w(FRAME_SIZE_DEF);

endpackage

// File: rtl/frame_sched_out_reg.sv
// One-entry output register for the sample stream: data plus index/first/last tags.
// A load always wins; an accept without a load empties the entry.
module frame_sched_out_reg
  import frame_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IW    = IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic [IW-1:0]    index_in,
  input  logic             first_in,
  input  logic             last_in,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [IW-1:0]    index,
  output logic             first,
  output logic             last
);

  // Entry holds its payload until accepted; a same-cycle load replaces it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
      first <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      index <= index_in;
      first <= first_in;
      last  <= last_in;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: drains FRAME_SIZE samples per filled window from the sample
// buffer into a tagged valid/ready stream, then commands a one-hop move.
// Optional build macro FRAME_SCHED_STATS_EN adds stall/starve cycle counters.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int FRAME_SIZE  = 306,
  parameter int MOVE_SIZE   = 123,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_i,
  input  logic                          buf_fill_done_i,
  input  logic                          buf_valid_i,
  input  logic [WIDTH-1:0]              buf_data_i,
  output logic                          buf_rd_en_o,
  output logic                          buf_start_move_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [WIDTH-1:0]              m_data_o,
  output logic [idx_w(FRAME_SIZE)-1:0]  m_index_o,
  output logic                          m_first_o,
  output logic                          m_last_o,
  output logic                          busy_o,
  output logic                          frame_done_o,
  output logic [FRAME_CNT_W-1:0]        frame_count_o
`ifdef FRAME_SCHED_STATS_EN
  ,
  output logic [31:0]                   stall_cycles_o,
  output logic [31:0]                   starve_cycles_o
`endif
);

  localparam int            IW       = idx_w(FRAME_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_SIZE - 1);

  // The hop itself is performed by the buffer; only sanity-check its size here
  if (MOVE_SIZE < 1 || MOVE_SIZE > FRAME_SIZE) begin : g_cfg_err
    $error("frame_scheduler: MOVE_SIZE must be in 1..FRAME_SIZE");
  end

  sched_state_t  state;
  logic          fill_pend;
  logic [IW-1:0] idx;
  logic          rd;

  // Read only when the buffer has data and the output entry is free or draining
  assign rd          = (state == READ) && buf_valid_i && (!m_valid_o || m_ready_i);
  assign buf_rd_en_o = rd;
  assign busy_o      = (state != IDLE);

  frame_sched_out_reg #(.WIDTH(WIDTH), .IW(IW)) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (rd),
    .ready    (m_ready_i),
    .data_in  (buf_data_i),
    .index_in (idx),
    .first_in (idx == '0),
    .last_in  (idx == LAST_IDX),
    .valid    (m_valid_o),
    .data     (m_data_o),
    .index    (m_index_o),
    .first    (m_first_o),
    .last     (m_last_o)
  );

  // Frame sequencing FSM; hop/done pulses are registered on entry to HOP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      fill_pend        <= 1'b0;
      idx              <= '0;
      buf_start_move_o <= 1'b0;
      frame_done_o     <= 1'b0;
      frame_count_o    <= '0;
    end else begin
      buf_start_move_o <= 1'b0;
      frame_done_o     <= 1'b0;
      // Remember a fill pulse that arrives before we are waiting for it
      if (buf_fill_done_i) fill_pend <= 1'b1;
      case (state)
        IDLE:      if (enable_i) state <= WAIT_FILL;
        WAIT_FILL: if (fill_pend || buf_fill_done_i) begin
          state     <= READ;
          idx       <= '0;
          fill_pend <= 1'b0;
        end
        READ:      if (rd) begin
          state <= (idx == LAST_IDX) ? DRAIN : GAP;
          if (idx != LAST_IDX) idx <= idx + 1'b1;
        end
        // One idle cycle so the buffer's registered valid reflects the read
        GAP:       state <= READ;
        DRAIN:     if (!m_valid_o) begin
          state            <= HOP;
          buf_start_move_o <= 1'b1;
          frame_done_o     <= 1'b1;
          frame_count_o    <= frame_count_o + 1'b1;
        end
        HOP:       state <= enable_i ? WAIT_FILL : IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

`ifdef FRAME_SCHED_STATS_EN
  // Saturating back-pressure and buffer-starvation cycle counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_o  <= '0;
      starve_cycles_o <= '0;
    end else begin
      if (m_valid_o && !m_ready_i && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 1'b1;
      if (state == READ && !buf_valid_i && starve_cycles_o != '1)
        starve_cycles_o <= starve_cycles_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler. A buffer model serves random samples
// and answers each hop with a fill pulse; a stream-level reference checks that
// the n-th accepted sample carries buffer word n and frame position n mod FS.
module tb_frame_scheduler;
  localparam int W  = 16;
  localparam int FS = 306;
  localparam int CW = 16;

  logic          clk = 0;
  logic          rst = 1;
  logic          enable_i = 0, man_fill = 0, auto_fill = 0;
  logic          buf_valid_i = 0, m_ready_i = 0;
  logic          buf_fill_done_i;
  logic [W-1:0]  buf_data_i;
  logic          buf_rd_en_o, buf_start_move_o, m_valid_o, m_first_o, m_last_o;
  logic          busy_o, frame_done_o;
  logic [W-1:0]  m_data_o;
  logic [8:0]    m_index_o;
  logic [CW-1:0] frame_count_o;
`ifdef FRAME_SCHED_STATS_EN
  logic [31:0]   stall_cycles_o, starve_cycles_o;
`endif

  int n_checks = 0, n_fail = 0;

  logic [W-1:0] mem [0:4095];
  logic [31:0]  rd_ptr = 0, acc_ptr = 0;
  int           acc_pos = 0, frames_model = 0, moves_cnt = 0, done_cnt = 0, fill_timer = 0;
  logic         rd_p = 0, acc_p = 0, move_p = 0, done_p = 0;
  logic         hold_prev = 0;
  logic [W-1:0] hold_data;
  logic [8:0]   hold_idx;

  assign buf_fill_done_i = man_fill | auto_fill;
  assign buf_data_i      = mem[rd_ptr[11:0]];

  always #5 clk = ~clk;

  frame_scheduler dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .buf_fill_done_i(buf_fill_done_i),
    .buf_valid_i(buf_valid_i), .buf_data_i(buf_data_i), .buf_rd_en_o(buf_rd_en_o),
    .buf_start_move_o(buf_start_move_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_index_o(m_index_o), .m_first_o(m_first_o), .m_last_o(m_last_o),
    .busy_o(busy_o), .frame_done_o(frame_done_o), .frame_count_o(frame_count_o)
`ifdef FRAME_SCHED_STATS_EN
    , .stall_cycles_o(stall_cycles_o), .starve_cycles_o(starve_cycles_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idx(input int k);
    int c = 0;
    while (!(m_valid_o && m_index_o == 9'(k)) && c < 4000) begin step(); c++; end
    chk("reach_index", 32'(m_valid_o && m_index_o == 9'(k)), 1);
  endtask

  task automatic wait_moves(input int n, input int budget);
    int c = 0;
    while (moves_cnt < n && c < budget) begin step(); c++; end
    chk("reach_hop", 32'(moves_cnt >= n), 1);
  endtask

  // Observe the stream mid-cycle; record what the coming edge will do
  always @(negedge clk) begin
    rd_p = 0; acc_p = 0; move_p = 0; done_p = 0;
    if (rst) hold_prev = 0;
    else begin
      if (m_valid_o && m_ready_i) begin
        chk("acc_data",  32'(m_data_o),  32'(mem[acc_ptr[11:0]]));
        chk("acc_index", 32'(m_index_o), 32'(acc_pos));
        chk("acc_first", 32'(m_first_o), 32'(acc_pos == 0));
        chk("acc_last",  32'(m_last_o),  32'(acc_pos == FS - 1));
        acc_p = 1;
      end
      if (hold_prev) begin
        chk("hold_data",  32'(m_data_o),  32'(hold_data));
        chk("hold_index", 32'(m_index_o), 32'(hold_idx));
      end
      if (buf_rd_en_o) chk("rd_allowed", 32'(buf_valid_i && (!m_valid_o || m_ready_i)), 1);
      if (buf_start_move_o || frame_done_o) begin
        chk("done_eq_move", 32'(frame_done_o), 32'(buf_start_move_o));
        chk("move_out_empty", 32'(m_valid_o), 0);
      end
      hold_prev = m_valid_o && !m_ready_i;
      hold_data = m_data_o;
      hold_idx  = m_index_o;
      rd_p = buf_rd_en_o; move_p = buf_start_move_o; done_p = frame_done_o;
    end
  end

  // Buffer model and stream reference, advanced on the active edge
  always @(posedge clk) begin
    if (rd_p) rd_ptr <= rd_ptr + 1;
    if (rst) begin
      acc_ptr <= rd_ptr; acc_pos <= 0; frames_model <= 0;
      moves_cnt <= 0; done_cnt <= 0; fill_timer <= 0; auto_fill <= 0;
    end else begin
      if (acc_p) begin
        acc_ptr <= acc_ptr + 1;
        acc_pos <= (acc_pos == FS - 1) ? 0 : acc_pos + 1;
        if (acc_pos == FS - 1) frames_model <= frames_model + 1;
      end
      if (move_p) moves_cnt <= moves_cnt + 1;
      if (done_p) done_cnt <= done_cnt + 1;
      fill_timer <= move_p ? 3 : (fill_timer != 0 ? fill_timer - 1 : 0);
      auto_fill  <= (fill_timer == 1);
    end
  end

  initial begin
    logic [W-1:0] sd;
    logic [8:0]   si;
    logic [31:0]  sp;
    int c;
`ifdef FRAME_SCHED_STATS_EN
    logic [31:0] stv0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (3) step();
    chk("rst_valid", 32'(m_valid_o), 0);
    chk("rst_rd_en", 32'(buf_rd_en_o), 0);
    chk("rst_busy",  32'(busy_o), 0);
    chk("rst_move",  32'(buf_start_move_o), 0);
    chk("rst_count", 32'(frame_count_o), 0);
    chk("rst_data",  32'(m_data_o), 0);
`ifdef FRAME_SCHED_STATS_EN
    chk("rst_stall", stall_cycles_o, 0);
    chk("rst_starve", starve_cycles_o, 0);
`endif
    rst = 0;
    step();

    // Frame 1: fill pulse in the same cycle enable rises, full throughput
    buf_valid_i = 1; m_ready_i = 1; enable_i = 1; man_fill = 1;
    step();
    man_fill = 0;
    wait_moves(1, 2000);
    chk("f1_count",  32'(frame_count_o), 1);
    chk("f1_frames", 32'(frames_model), 1);
    chk("f1_pos",    32'(acc_pos), 0);

    // Frame 2: back-pressure at index 50
    wait_idx(50);
    m_ready_i = 0;
    sd = m_data_o; si = m_index_o;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid", 32'(m_valid_o), 1);
      chk("bp_data",  32'(m_data_o), 32'(sd));
      chk("bp_index", 32'(m_index_o), 32'(si));
      chk("bp_no_rd", 32'(buf_rd_en_o), 0);
    end
    m_ready_i = 1;

    // Buffer starvation at index 120 (first starved cycle is the gap cycle)
    wait_idx(120);
`ifdef FRAME_SCHED_STATS_EN
    stv0 = starve_cycles_o;
`endif
    buf_valid_i = 0;
    for (int i = 0; i < 21; i++) begin
      step();
      if (i == 10) chk("starve_no_rd", 32'(buf_rd_en_o), 0);
    end
    buf_valid_i = 1;
`ifdef FRAME_SCHED_STATS_EN
    chk("starve_cnt", starve_cycles_o - stv0, 20);
`endif
    step();
    chk("starve_busy", 32'(busy_o), 1);
    wait_idx(121);
    wait_moves(2, 2000);

    // Frame 3: drop enable at index 100, frame still completes
    wait_idx(100);
    enable_i = 0;
    wait_moves(3, 2000);
    chk("en_pos", 32'(acc_pos), 0);
    step(); step();
    sp = rd_ptr;
    repeat (20) step();
    chk("en_idle",  32'(busy_o), 0);
    chk("en_no_rd", rd_ptr, sp);
    chk("en_count", 32'(frame_count_o), 3);
    chk("en_moves", 32'(moves_cnt), 3);

    // Frame 4: pending fill is consumed; reset at index 200
    enable_i = 1;
    wait_idx(200);
    rst = 1;
    step();
    chk("mrst_valid", 32'(m_valid_o), 0);
    chk("mrst_data",  32'(m_data_o), 0);
    chk("mrst_index", 32'(m_index_o), 0);
    chk("mrst_tags",  32'({m_first_o, m_last_o}), 0);
    chk("mrst_busy",  32'(busy_o), 0);
    chk("mrst_count", 32'(frame_count_o), 0);
    chk("mrst_pulse", 32'({buf_start_move_o, frame_done_o, buf_rd_en_o}), 0);
    rst = 0;
    sp = rd_ptr;
    repeat (4) step();
    chk("mrst_wait_busy", 32'(busy_o), 1);
    chk("mrst_wait_no_rd", rd_ptr, sp);
    man_fill = 1;
    step();
    man_fill = 0;
    wait_idx(0);
    chk("restart_first", 32'(m_first_o), 1);

    // Three frames with random ready/valid
    c = 0;
    while (moves_cnt < 3 && c < 15000) begin
      buf_valid_i = ($urandom_range(0, 3) != 0);
      m_ready_i   = ($urandom_range(0, 3) != 0);
      step();
      c++;
    end
    chk("rnd_hops",   32'(moves_cnt), 3);
    chk("rnd_done",   32'(done_cnt), 3);
    chk("rnd_frames", 32'(frames_model), 3);
    chk("rnd_count",  32'(frame_count_o), 3);
    buf_valid_i = 1; m_ready_i = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
